// File: rtl/spi_target.sv
// Oversampled SPI mode-0 responder with 2-deep RX/TX byte FIFOs and sticky error flags.
// Define SPI_TARGET_BYTE_COUNT_EN to add the per-frame byte_count[12:0] output.
//
// state | meaning
// IDLE  | no frame; MISO released high, MISO_oe low
// LOAD  | one cycle after SS_n fall: fetch first TX byte
// SHIFT | frame active; bits move on detected SCLK edges
module spi_target (
  input  logic        C100M,
  input  logic        RESET_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_start,
  output logic        frame_end,
  output logic        rx_overrun,
  output logic        tx_underrun,
  input  logic        clr_flags
`ifdef SPI_TARGET_BYTE_COUNT_EN
  ,
  output logic [12:0] byte_count
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  ss_sync_q, ss_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s2;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        oe_q, oe_d;
  logic        reload_q, reload_d;
  logic        urun_pend_q, urun_pend_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_underrun_q, tx_underrun_d;
  logic        byte_done, set_urun;

  logic [7:0]  tx_mem_q [2];
  logic [7:0]  tx_mem_d [2];
  logic        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [1:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_push, tx_pop, tx_empty;
  logic [7:0]  tx_head;

  logic [7:0]  rx_mem_q [2];
  logic [7:0]  rx_mem_d [2];
  logic        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic        rx_push, rx_pop;

  // SS_n stages reset low so a select held through reset never looks like a fresh fall.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    ss_sync_d   = {ss_sync_q[1:0], SS_n};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign mosi_s2   = mosi_sync_q[1];

  assign tx_empty = (tx_cnt_q == 2'd0);
  assign tx_head  = tx_mem_q[tx_rd_q];

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    oe_d          = oe_q;
    reload_d      = reload_q;
    urun_pend_d   = urun_pend_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    byte_done     = 1'b0;
    set_urun      = 1'b0;
    tx_pop        = 1'b0;
    if (ss_rise && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      frame_end_d = 1'b1;
      oe_d        = 1'b0;
      tx_shift_d  = 8'hFF;
      bit_cnt_d   = 3'd0;
      reload_d    = 1'b0;
      urun_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            state_d       = ST_LOAD;
            frame_start_d = 1'b1;
          end
        end
        ST_LOAD: begin
          tx_pop      = ~tx_empty;
          tx_shift_d  = tx_empty ? 8'hFF : tx_head;
          set_urun    = tx_empty;
          oe_d        = 1'b1;
          bit_cnt_d   = 3'd0;
          reload_d    = 1'b0;
          urun_pend_d = 1'b0;
          state_d     = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_d  = {rx_shift_q[6:0], mosi_s2};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            set_urun    = urun_pend_q;
            urun_pend_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              byte_done = 1'b1;
              reload_d  = 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload_q) begin
              // An empty FIFO here only counts as underrun once the master clocks the slot.
              reload_d    = 1'b0;
              tx_pop      = ~tx_empty;
              tx_shift_d  = tx_empty ? 8'hFF : tx_head;
              urun_pend_d = tx_empty;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_push  = tx_valid && (tx_cnt_q != 2'd2);
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = tx_data;
      tx_wr_d           = ~tx_wr_q;
    end
    if (tx_pop) tx_rd_d = ~tx_rd_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 2'd1;
      2'b01:   tx_cnt_d = tx_cnt_q - 2'd1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // A full RX FIFO still accepts the byte when the head is popped in the same cycle.
  always_comb begin
    rx_pop   = rx_ready && (rx_cnt_q != 2'd0);
    rx_push  = byte_done && ((rx_cnt_q != 2'd2) || rx_pop);
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_shift_d;
      rx_wr_d           = ~rx_wr_q;
    end
    if (rx_pop) rx_rd_d = ~rx_rd_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 2'd1;
      2'b01:   rx_cnt_d = rx_cnt_q - 2'd1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_comb begin
    rx_overrun_d  = clr_flags ? 1'b0 : (rx_overrun_q | (byte_done & ~rx_push));
    tx_underrun_d = clr_flags ? 1'b0 : (tx_underrun_q | set_urun);
  end

  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= ST_IDLE;
      sclk_sync_q   <= 3'b000;
      ss_sync_q     <= 3'b000;
      mosi_sync_q   <= 2'b00;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'hFF;
      oe_q          <= 1'b0;
      reload_q      <= 1'b0;
      urun_pend_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      tx_mem_q[0]   <= 8'h00;
      tx_mem_q[1]   <= 8'h00;
      tx_wr_q       <= 1'b0;
      tx_rd_q       <= 1'b0;
      tx_cnt_q      <= 2'd0;
      rx_mem_q[0]   <= 8'h00;
      rx_mem_q[1]   <= 8'h00;
      rx_wr_q       <= 1'b0;
      rx_rd_q       <= 1'b0;
      rx_cnt_q      <= 2'd0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      oe_q          <= oe_d;
      reload_q      <= reload_d;
      urun_pend_q   <= urun_pend_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      tx_mem_q      <= tx_mem_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_mem_q      <= rx_mem_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      rx_cnt_q      <= rx_cnt_d;
    end
  end

  assign MISO        = oe_q ? tx_shift_q[7] : 1'b1;
  assign MISO_oe     = oe_q;
  assign tx_ready    = (tx_cnt_q != 2'd2);
  assign rx_data     = rx_mem_q[rx_rd_q];
  assign rx_valid    = (rx_cnt_q != 2'd0);
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

`ifdef SPI_TARGET_BYTE_COUNT_EN
  logic [12:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (frame_start_d) byte_cnt_d = 13'd0;
    else if (byte_done && byte_cnt_q != 13'h1FFF) byte_cnt_d = byte_cnt_q + 13'd1;
  end

  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) byte_cnt_q <= 13'd0;
    else          byte_cnt_q <= byte_cnt_d;
  end

  assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: random SPI frames against a queue-based byte-level model.
// Pins are driven 1 ns after a C100M rise; SCLK runs at C100M/8.
module tb_spi_target;

  logic       C100M = 1'b0;
  logic       RESET_n = 1'b0;
  logic       SCLK = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clr_flags = 1'b0;
  logic       MISO, MISO_oe, tx_ready, rx_valid;
  logic [7:0] rx_data;
  logic       frame_start, frame_end, rx_overrun, tx_underrun;
`ifdef SPI_TARGET_BYTE_COUNT_EN
  logic [12:0] byte_count;
`endif

  always #5 C100M = ~C100M;

  spi_target dut (
    .C100M(C100M), .RESET_n(RESET_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_start(frame_start), .frame_end(frame_end),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .clr_flags(clr_flags)
`ifdef SPI_TARGET_BYTE_COUNT_EN
    , .byte_count(byte_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;

  always @(negedge C100M) begin
    if (frame_start === 1'b1) fs_cnt++;
    if (frame_end === 1'b1) fe_cnt++;
  end

  // Byte-level model: FIFO contents as queues, sticky flags as bits.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_ovr = 1'b0;
  logic       m_urun = 1'b0;
  logic [7:0] exp_popped = 8'h00;

  logic [7:0] f_mosi [8];
  logic [7:0] f_miso [8];
  logic [7:0] e_miso [8];
  logic       oe_in_frame, urun_in_frame, oe_after, miso_after;
  logic [7:0] got_popped;

  task automatic push_tx(input logic [7:0] b);
    logic exp_rdy;
    exp_rdy = (m_tx.size() < 2);
    n_checks++;
    if (tx_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL tx_ready before push %h: got %b expected %b", b, tx_ready, exp_rdy);
    end
    tx_data = b; tx_valid = 1'b1;
    #10;
    tx_valid = 1'b0;
    if (exp_rdy) m_tx.push_back(b);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    #10;
    clr_flags = 1'b0;
    m_ovr = 1'b0; m_urun = 1'b0;
    n_checks++;
    if (rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_flags: got ovr=%b urun=%b expected 0 0", rx_overrun, tx_underrun);
    end
  endtask

  // Drives one frame of nbits; pulses rx_ready in the cycle the rise of bit pop_bit is detected.
  task automatic spi_frame(input int nbits, input int pop_bit);
    SS_n = 1'b0;
    #60;
    oe_in_frame = MISO_oe;
    urun_in_frame = tx_underrun;
    for (int b = 0; b < nbits; b++) begin
      MOSI = f_mosi[b/8][7-(b%8)];
      f_miso[b/8][7-(b%8)] = MISO;
      SCLK = 1'b1;
      if (b == pop_bit) begin
        #20;
        got_popped = rx_data;
        rx_ready = 1'b1;
        #10;
        rx_ready = 1'b0;
        #10;
      end else begin
        #40;
      end
      SCLK = 1'b0;
      #40;
    end
    SS_n = 1'b1;
    #40;
    oe_after = MISO_oe;
    miso_after = MISO;
    #30;
  endtask

  // Slot k loads at LOAD (k=0) or on the fall after byte k-1; only clocked slots count as underrun.
  task automatic model_frame(input int nbits, input int pop_bit);
    int nfull;
    nfull = nbits / 8;
    for (int k = 0; k <= nfull; k++) begin
      if (m_tx.size() != 0) e_miso[k] = m_tx.pop_front();
      else begin
        e_miso[k] = 8'hFF;
        if (k == 0 || 8 * k < nbits) m_urun = 1'b1;
      end
      if (k < nfull) begin
        if (pop_bit >= 0 && pop_bit / 8 == k) exp_popped = m_rx.pop_front();
        if (m_rx.size() < 2) m_rx.push_back(f_mosi[k]);
        else m_ovr = 1'b1;
      end
    end
  endtask

  task automatic verify_frame(input string tag, input int nbits, input int fs0, input int fe0);
    int nfull;
    int rem;
    logic [7:0] mask;
    logic exp_valid;
    nfull = nbits / 8;
    rem = nbits % 8;
    for (int k = 0; k < nfull; k++) begin
      n_checks++;
      if (f_miso[k] !== e_miso[k]) begin
        n_fail++;
        $display("FAIL %s miso byte %0d: got %h expected %h", tag, k, f_miso[k], e_miso[k]);
      end
    end
    if (rem != 0) begin
      mask = 8'hFF << (8 - rem);
      n_checks++;
      if ((f_miso[nfull] & mask) !== (e_miso[nfull] & mask)) begin
        n_fail++;
        $display("FAIL %s miso partial: got %h expected %h", tag, f_miso[nfull] & mask, e_miso[nfull] & mask);
      end
    end
    n_checks++;
    if (oe_in_frame !== 1'b1 || oe_after !== 1'b0 || miso_after !== 1'b1) begin
      n_fail++;
      $display("FAIL %s oe/idle: got oe_in=%b oe_after=%b miso_after=%b expected 1 0 1",
               tag, oe_in_frame, oe_after, miso_after);
    end
    n_checks++;
    if (fs_cnt - fs0 != 1 || fe_cnt - fe0 != 1) begin
      n_fail++;
      $display("FAIL %s frame pulses: got start=%0d end=%0d expected 1 1", tag, fs_cnt - fs0, fe_cnt - fe0);
    end
    n_checks++;
    if (rx_overrun !== m_ovr || tx_underrun !== m_urun) begin
      n_fail++;
      $display("FAIL %s flags: got ovr=%b urun=%b expected %b %b", tag, rx_overrun, tx_underrun, m_ovr, m_urun);
    end
    exp_valid = (m_rx.size() != 0);
    n_checks++;
    if (rx_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL %s rx_valid: got %b expected %b", tag, rx_valid, exp_valid);
    end
  endtask

  task automatic drain_rx(input string tag);
    while (m_rx.size() != 0) begin
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== m_rx[0]) begin
        n_fail++;
        $display("FAIL %s rx head: got valid=%b data=%h expected 1 %h", tag, rx_valid, rx_data, m_rx[0]);
      end
      rx_ready = 1'b1;
      #10;
      rx_ready = 1'b0;
      void'(m_rx.pop_front());
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rx empty: got valid=%b expected 0", tag, rx_valid);
    end
  endtask

  task automatic run_checked(input string tag, input int nbits, input int pop_bit);
    int fs0, fe0;
    fs0 = fs_cnt; fe0 = fe_cnt;
    spi_frame(nbits, pop_bit);
    model_frame(nbits, pop_bit);
    verify_frame(tag, nbits, fs0, fe0);
  endtask

  task automatic test_reset();
    n_checks++;
    if (MISO !== 1'b1 || MISO_oe !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset datapath: got miso=%b oe=%b trdy=%b rvld=%b rdata=%h expected 1 0 1 0 00",
               MISO, MISO_oe, tx_ready, rx_valid, rx_data);
    end
    n_checks++;
    if (frame_start !== 1'b0 || frame_end !== 1'b0 || rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pulses/flags: got %b%b%b%b expected 0000", frame_start, frame_end, rx_overrun, tx_underrun);
    end
    RESET_n = 1'b1;
    #100;
    n_checks++;
    if (fs_cnt != 0 || fe_cnt != 0 || MISO_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL post-reset idle: got fs=%0d fe=%0d oe=%b expected 0 0 0", fs_cnt, fe_cnt, MISO_oe);
    end
  endtask

  task automatic test_single_byte();
    push_tx(8'hA5);
    f_mosi[0] = 8'h3C;
    run_checked("single_byte", 8, -1);
`ifdef SPI_TARGET_BYTE_COUNT_EN
    n_checks++;
    if (byte_count !== 13'd1) begin
      n_fail++;
      $display("FAIL byte_count: got %0d expected 1", byte_count);
    end
`endif
    drain_rx("single_byte");
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 3; i++) f_mosi[i] = 8'(i + 1);
    run_checked("overrun", 24, -1);
    clear_flags();
    drain_rx("overrun");
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 2; i++) f_mosi[i] = 8'($urandom);
    run_checked("underrun", 16, -1);
    n_checks++;
    if (urun_in_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun at LOAD: got %b expected 1", urun_in_frame);
    end
    drain_rx("underrun");
    clear_flags();
  endtask

  task automatic test_tx_full();
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    for (int i = 0; i < 2; i++) f_mosi[i] = 8'($urandom);
    run_checked("tx_full", 16, -1);
    drain_rx("tx_full");
  endtask

  task automatic test_partial();
    push_tx(8'($urandom));
    push_tx(8'($urandom));
    f_mosi[0] = 8'($urandom);
    run_checked("partial", 5, -1);
    f_mosi[0] = 8'($urandom);
    run_checked("after_partial", 8, -1);
    drain_rx("partial");
    clear_flags();
  endtask

  task automatic test_rx_full_pop();
    for (int i = 0; i < 2; i++) f_mosi[i] = 8'($urandom);
    push_tx(8'($urandom));
    run_checked("rx_fill", 16, -1);
    f_mosi[0] = 8'($urandom);
    push_tx(8'($urandom));
    run_checked("rx_full_pop", 8, 7);
    n_checks++;
    if (got_popped !== exp_popped) begin
      n_fail++;
      $display("FAIL rx_full_pop popped: got %h expected %h", got_popped, exp_popped);
    end
    drain_rx("rx_full_pop");
    clear_flags();
  endtask

  task automatic test_random();
    int npush, nbytes;
    for (int it = 0; it < 5; it++) begin
      npush = $urandom_range(0, 3);
      for (int p = 0; p < npush; p++) push_tx(8'($urandom));
      nbytes = $urandom_range(1, 3);
      for (int i = 0; i < nbytes; i++) f_mosi[i] = 8'($urandom);
      run_checked("random", 8 * nbytes, -1);
      drain_rx("random");
      clear_flags();
    end
  endtask

  task automatic test_reset_mid_frame();
    int fs0, fe0;
    push_tx(8'($urandom));
    SS_n = 1'b0;
    #60;
    for (int b = 0; b < 3; b++) begin
      MOSI = b[0];
      SCLK = 1'b1; #40; SCLK = 1'b0; #40;
    end
    RESET_n = 1'b0;
    #10;
    m_tx.delete(); m_rx.delete(); m_ovr = 1'b0; m_urun = 1'b0;
    n_checks++;
    if (MISO !== 1'b1 || MISO_oe !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00 ||
        rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-frame reset: got miso=%b oe=%b trdy=%b rvld=%b rdata=%h ovr=%b urun=%b expected 1 0 1 0 00 0 0",
               MISO, MISO_oe, tx_ready, rx_valid, rx_data, rx_overrun, tx_underrun);
    end
    #20;
    fs0 = fs_cnt; fe0 = fe_cnt;
    RESET_n = 1'b1;
    #200;
    n_checks++;
    if (fs_cnt != fs0 || MISO_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL held-select after reset: got starts=%0d oe=%b expected 0 0", fs_cnt - fs0, MISO_oe);
    end
    SS_n = 1'b1;
    #100;
    n_checks++;
    if (fe_cnt != fe0) begin
      n_fail++;
      $display("FAIL spurious frame_end: got %0d expected 0", fe_cnt - fe0);
    end
    push_tx(8'($urandom));
    f_mosi[0] = 8'($urandom);
    run_checked("post_reset", 8, -1);
    drain_rx("post_reset");
  endtask

  initial begin
    #16;
    test_reset();
    test_single_byte();
    test_overrun();
    test_underrun();
    test_tx_full();
    test_partial();
    test_rx_full_pop();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (responder) for the far end of the SD-card style SPI link: an external SPI master drives SCLK, SS_n and MOSI, and this block returns data on MISO. It runs entirely in the C100M domain. The SPI pins are oversampled, and bytes are exchanged with on-board logic through 2-entry RX and TX FIFOs using valid/ready handshakes. Sticky error flags and frame pulses let a register wrapper raise INT2_n without re-deriving SPI state.

## Interface
- No parameters.
- C100M  input  1  system clock, 100 MHz.
- RESET_n  input  1  reset, asynchronous, active-low.
- SCLK  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to C100M.
- SS_n  input  1  SPI select, active-low, asynchronous.
- MOSI  input  1  master-out data, MSB first.
- MISO  output  1  target-out data, MSB first.
- MISO_oe  output  1  MISO driver enable; high only while a frame is active.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  TX FIFO has space.
- rx_data  output  8  head of RX FIFO.
- rx_valid  output  1  RX FIFO is non-empty.
- rx_ready  input  1  consumer pops the RX head.
- frame_start  output  1  one-cycle pulse when SS_n falls.
- frame_end  output  1  one-cycle pulse when SS_n rises.
- rx_overrun  output  1  sticky: a received byte was dropped because the RX FIFO was full.
- tx_underrun  output  1  sticky: a byte slot started while the TX FIFO was empty.
- clr_flags  input  1  clears both sticky flags.

## Operation
- Synchronisers: SCLK, SS_n and MOSI each pass through 2 flops and a third edge-detect flop. Edges are detected from stages 2 and 3. MOSI is sampled from stage 2 on the cycle the SCLK rising edge is detected.
- States: IDLE, LOAD, SHIFT.
  - IDLE -> LOAD on detected SS_n fall. frame_start pulses.
  - LOAD: pop the TX head into the shift-out register, or load 0xFF and set tx_underrun if the FIFO is empty. Drive bit 7 on MISO, clear bit_cnt, then go to SHIFT. LOAD takes 1 cycle.
  - SHIFT: on each SCLK rise, shift MOSI into rx_shift and increment the 3-bit bit_cnt.
  - SHIFT: on each SCLK fall, shift MISO out, except on the fall that follows bit_cnt wrapping 7->0. On that fall, reload from the TX FIFO as in LOAD.
  - On the 8th rise, push rx_shift into the RX FIFO. If the FIFO is full, drop the byte and set rx_overrun.
  - Any state -> IDLE on detected SS_n rise. A partial byte (bit_cnt != 0) is discarded with no push and no flag. frame_end pulses, MISO_oe falls, MISO returns to 1.
- FIFOs: 2 entries each, with 1-bit pointers and a 2-bit count.
  - Push and pop are allowed in the same cycle; the count stays the same.
  - tx_ready = count < 2. A push with tx_ready low is ignored.
  - rx_valid = count != 0. rx_ready while empty is ignored.
  - A byte-complete push in the same cycle as an rx_ready pop on a full RX FIFO succeeds; no overrun is flagged.
- Sticky flags: clr_flags has priority over a simultaneous set in the same cycle.
- TX FIFO across frames: the contents persist across frames and are not flushed on frame_end.

## Timing
- Reset values:
  - MISO=1, MISO_oe=0.
  - tx_ready=1, rx_valid=0, rx_data=0x00.
  - frame_start=0, frame_end=0, rx_overrun=0, tx_underrun=0.
  - State IDLE, both FIFOs empty.
- Pin-to-detect latency: 3 C100M cycles.
- MISO update: at most 4 cycles (40 ns) after the SCLK falling pin edge.
- Maximum supported SCLK: C100M/8 (12.5 MHz). Each SCLK level must last at least 4 cycles.
- SS_n to first bit: the master must hold SS_n low at least 5 cycles before the first SCLK rise. MISO_oe and bit 7 are valid 4 cycles after the SS_n fall.
- RX byte latency: rx_valid rises 1 cycle after the detected 8th rise.
- MISO_oe: falls 1 cycle after the SS_n rise is detected.
- RESET_n assertion mid-frame: immediate return to reset values. After release, the block waits for a fresh SS_n fall; SS_n held low through reset does not start a frame.

## Configuration
- SPI_TARGET_BYTE_COUNT_EN:
  - Defined: adds output byte_count[12:0]. It is cleared on frame_start, increments on each completed byte (including dropped ones), saturates at 8191, and holds after frame_end until the next frame_start.
  - Undefined: the port and counter do not exist.

## Test plan
- Reset, push 0xA5, frame of 1 byte with MOSI=0x3C at SCLK=C100M/8 -> MISO shifts 1010_0101; rx_data=0x3C, rx_valid=1; frame_start/frame_end each pulse once; no flags.
- Frame of 3 bytes (0x01,0x02,0x03) with rx_ready held low -> 0x01 and 0x02 are kept; 0x03 is dropped; rx_overrun=1 until clr_flags.
- TX FIFO empty, 2-byte frame -> MISO sends 0xFF,0xFF; tx_underrun=1 from the first LOAD.
- Push 0x11,0x22, then push 0x33 while tx_ready=0 -> 0x33 is ignored; frame sends 0x11,0x22.
- SS_n rises after 5 bits -> no RX push, frame_end pulses, MISO_oe=0 within 4 cycles, next frame starts cleanly at bit 7.
- RESET_n low mid-byte with SS_n held low -> all outputs at reset values; no frame_start until SS_n goes high then low again.
